fifo_uart_tx: RTL and testbench

Serial transmit stage that drains the 8-bit, 16-deep FIFO and drives a UART line, 8 data bits, LSB first, optional parity, one stop bit. It sits directly downstream of the FIFO's read port. It pops a byte only when the FIFO reports non-empty, captures the show-ahead read data, and shifts it out at a parameterised bit rate.

---
 rtl/fifo_uart_tx.sv | 144 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - UART transmit stage draining a show-ahead FIFO
//
// Pops one byte at a time from an 8-bit show-ahead FIFO and sends it as
// start bit, 8 data bits LSB first, optional parity bit, one stop bit.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-high reset
//   tx_en      in   permits starting new frames (looked at only while idle)
//   Empty      in   FIFO empty flag (registered in the FIFO, one cycle stale)
//   R_data     in   FIFO show-ahead read data, valid with R_en
//   R_en       out  single-cycle pop strobe
//   tx         out  serial line, idle high, driven from a flop
//   busy       out  high whenever a frame is in progress
//   frame_done out  one-cycle pulse in the last cycle of the stop bit
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       Empty,
  input  logic [7:0] R_data,
  output logic       R_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [1:0]    guard_q, guard_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      par_q   <= 1'b0;
      guard_q <= 2'd2;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      guard_q <= guard_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    // The guard keeps us from trusting Empty in the cycle after reset
    // release and in the cycle after a pop, when the flag is still stale.
    R_en       = (state_q == S_IDLE) && tx_en && !Empty && (guard_q == 2'd0);
    bit_end    = (baud_q == BAUD_MAX);
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    frame_done = 1'b0;
    guard_d    = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;

    // States only change on a bit boundary, so the wrap to zero here is
    // also the clear-on-state-change.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (R_en) begin
          shift_d = R_data;
          par_d   = (^R_data) ^ PAR_ODD;
          baud_d  = '0;
          guard_d = 2'd2;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is computed for the state being entered so the flop
    // output lines up with state_q without a cycle of skew.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic [2:0] empty = 3'b111;
  logic [2:0] r_en, txl, busy, fdone;
  logic [7:0] r_data [3];

  always #5 clk = ~clk;

  // Instance 0: no parity, 1: even parity, 2: odd parity.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    fifo_uart_tx #(
      .CLKS_PER_BIT(C),
      .PARITY_EN   ((g > 0) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .tx_en     (tx_en),
      .Empty     (empty[g]),
      .R_data    (r_data[g]),
      .R_en      (r_en[g]),
      .tx        (txl[g]),
      .busy      (busy[g]),
      .frame_done(fdone[g])
    );
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // FIFO model per instance
  logic [7:0] mem [3][16];
  int head [3] = '{0, 0, 0};
  int cnt  [3] = '{0, 0, 0};
  logic ren_cap [3] = '{1'b0, 1'b0, 1'b0};

  // Frame model per instance
  int fpos [3] = '{-1, -1, -1};
  logic [10:0] fbits [3];
  int since_pop [3] = '{2, 2, 2};
  int since_rst = 0;

  // Independent line monitor per instance
  int mon_cnt [3] = '{-1, -1, -1};
  logic mon_bits [3][11];
  int fd_len [3] = '{0, 0, 0};
  int start_cyc [3] = '{0, 0, 0};
  int prev_start [3] = '{0, 0, 0};
  int ren_count [3] = '{0, 0, 0};
  int first_ren_cyc [3] = '{-1, -1, -1};

  function automatic int pe(int i);
    return (i > 0) ? 1 : 0;
  endfunction

  function automatic logic po(int i);
    return (i == 2);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: model and monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    int nb;
    logic exp_idle, exp_ren, etx, ebusy, efd;
    logic [7:0] b;
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        chk("rst_tx", int'(txl[i]), 1);
        chk("rst_busy", int'(busy[i]), 0);
        chk("rst_frame_done", int'(fdone[i]), 0);
        chk("rst_r_en", int'(r_en[i]), 0);
        fpos[i] = -1;
        since_pop[i] = 2;
        mon_cnt[i] = -1;
        ren_cap[i] = 1'b0;
      end else begin
        nb = 10 + pe(i);
        exp_idle = (fpos[i] < 0);
        exp_ren = exp_idle && tx_en && !empty[i] && (since_rst >= 2) && (since_pop[i] >= 2);
        if (exp_idle) begin
          etx = 1'b1; ebusy = 1'b0; efd = 1'b0;
        end else begin
          etx = fbits[i][fpos[i] / C];
          ebusy = 1'b1;
          efd = (fpos[i] == nb * C - 1);
        end
        chk("tx", int'(txl[i]), int'(etx));
        chk("busy", int'(busy[i]), int'(ebusy));
        chk("frame_done", int'(fdone[i]), int'(efd));
        chk("r_en", int'(r_en[i]), int'(exp_ren));
        ren_cap[i] = r_en[i];

        if (mon_cnt[i] < 0 && !txl[i]) begin
          prev_start[i] = start_cyc[i];
          start_cyc[i] = cyc;
          mon_cnt[i] = 0;
        end
        if (mon_cnt[i] >= 0) begin
          if ((mon_cnt[i] % C) == C / 2 && (mon_cnt[i] / C) < 11)
            mon_bits[i][mon_cnt[i] / C] = txl[i];
          if (fdone[i]) begin
            fd_len[i] = mon_cnt[i] + 1;
            mon_cnt[i] = -1;
          end else if (mon_cnt[i] > 60) begin
            mon_cnt[i] = -1;
          end else begin
            mon_cnt[i]++;
          end
        end
        if (r_en[i]) begin
          ren_count[i]++;
          if (first_ren_cyc[i] < 0) first_ren_cyc[i] = cyc;
        end

        if (exp_ren) begin
          b = mem[i][head[i]];
          fbits[i] = 11'h7FF;
          fbits[i][0] = 1'b0;
          fbits[i][8:1] = b;
          if (pe(i) != 0) fbits[i][9] = (^b) ^ po(i);
          fpos[i] = 0;
          since_pop[i] = 0;
        end else begin
          if (fpos[i] >= 0) begin
            fpos[i]++;
            if (fpos[i] == nb * C) fpos[i] = -1;
          end
          if (since_pop[i] < 100) since_pop[i]++;
        end
      end
    end
    if (rst) since_rst = 0;
    else if (since_rst < 100) since_rst++;
  end

  // FIFO update just after each edge: Empty reflects the count from
  // before this edge's pop, so it lags the pointers by one cycle.
  task automatic tick();
    logic new_e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      new_e = (cnt[i] == 0);
      if (ren_cap[i] && cnt[i] > 0) begin
        head[i] = (head[i] + 1) % 16;
        cnt[i]--;
      end
      empty[i] = new_e;
      r_data[i] = mem[i][head[i]];
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic push(logic [7:0] b);
    for (int i = 0; i < 3; i++) begin
      mem[i][(head[i] + cnt[i]) % 16] = b;
      cnt[i]++;
      r_data[i] = mem[i][head[i]];
    end
  endtask

  initial begin
    logic [9:0] exp_a5;
    logic [7:0] c3;
    int rel_cyc;
    int w;
    exp_a5 = 10'b1_10100101_0;
    c3 = 8'hC3;
    for (int i = 0; i < 3; i++) r_data[i] = 8'h00;
    tx_en = 1'b1;

    // Asynchronous reset with no clock edge in between.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async_rst_tx", int'(txl[i]), 1);
      chk("async_rst_busy", int'(busy[i]), 0);
      chk("async_rst_frame_done", int'(fdone[i]), 0);
      chk("async_rst_r_en", int'(r_en[i]), 0);
    end

    // Single byte 0xA5, Empty already low at release.
    push(8'hA5);
    run(3);
    rst = 1'b0;
    rel_cyc = cyc;
    run(50);
    chk("first_pop_delay", first_ren_cyc[0] - rel_cyc, 3);
    for (int k = 0; k < 10; k++) chk("a5_line_bit", int'(mon_bits[0][k]), int'(exp_a5[k]));
    chk("a5_len_noparity", fd_len[0], 40);
    chk("a5_len_even", fd_len[1], 44);
    chk("a5_len_odd", fd_len[2], 44);
    chk("a5_parity_even", int'(mon_bits[1][9]), 0);
    chk("a5_parity_odd", int'(mon_bits[2][9]), 1);
    chk("a5_pops", ren_count[0], 1);
    chk("a5_busy_after", int'(busy[0]), 0);

    // Back-to-back 0x00, 0xFF.
    push(8'h00);
    push(8'hFF);
    run(110);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_pops", ren_count[i], 3);
      chk("b2b_fifo_left", cnt[i], 0);
    end
    chk("b2b_period_noparity", start_cyc[0] - prev_start[0], 41);
    chk("b2b_period_parity", start_cyc[1] - prev_start[1], 45);
    chk("ff_data_bit", int'(mon_bits[0][4]), 1);

    // Parity on 0x07.
    push(8'h07);
    run(60);
    chk("p07_parity_even", int'(mon_bits[1][9]), 1);
    chk("p07_parity_odd", int'(mon_bits[2][9]), 0);
    chk("p07_len_even", fd_len[1], 44);
    chk("p07_len_odd", fd_len[2], 44);
    chk("p07_len_noparity", fd_len[0], 40);

    // tx_en dropped during DATA of the first of three bytes.
    push(8'h11);
    push(8'h22);
    push(8'h33);
    run(12);
    tx_en = 1'b0;
    run(60);
    for (int i = 0; i < 3; i++) begin
      chk("txen_drop_fifo_left", cnt[i], 2);
      chk("txen_drop_pops", ren_count[i], 5);
    end
    tx_en = 1'b1;
    run(100);
    for (int i = 0; i < 3; i++) begin
      chk("txen_restore_pops", ren_count[i], 7);
      chk("txen_restore_fifo_left", cnt[i], 0);
    end
    chk("byte33_bit0", int'(mon_bits[0][1]), 1);
    chk("byte33_bit2", int'(mon_bits[0][3]), 0);

    // Reset during DATA bit 3 of 0x5A; 0xC3 must follow in full.
    push(8'h5A);
    push(8'hC3);
    w = 0;
    while (ren_count[0] != 8 && w < 30) begin
      tick();
      w++;
    end
    chk("pop_5a_seen", ren_count[0], 8);
    run(17);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("midframe_rst_tx", int'(txl[i]), 1);
      chk("midframe_rst_busy", int'(busy[i]), 0);
    end
    run(2);
    rst = 1'b0;
    run(110);
    for (int i = 0; i < 3; i++) begin
      chk("after_rst_pops", ren_count[i], 9);
      chk("after_rst_fifo_left", cnt[i], 0);
    end
    for (int k = 0; k < 8; k++) chk("c3_data_bit", int'(mon_bits[0][k + 1]), int'(c3[k]));
    chk("c3_len", fd_len[0], 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
